// File: rtl/text_tile_renderer.sv
// text_tile_renderer
//   Character-cell text overlay placed between the VGA sync unit and the RGB
//   mux. A COLS x ROWS tile RAM holds {char[6:0], attr[3:0]} per cell; glyphs
//   come from the shared 8x16 font ROM, scaled by 2^SCALE_LOG2.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   pixel_x, pixel_y      current pixel coordinates from the sync unit
//   wr_en/wr_col/wr_row   cell write request and target cell
//   wr_char, wr_attr      ASCII code, attribute ([3]=blink, [2:0]=palette)
//   wr_ready              high while writes are accepted (IDLE)
//   clear_req             one-cycle pulse: blank every cell
//   cursor_en/col/row     blinking block cursor
//   rom_addr, rom_data    font ROM port, data valid one cycle after address
//   text_on, text_RGB     window flag and colour, 3 clk after the pixel
module text_tile_renderer #(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned ORIGIN_X   = 0,
    parameter int unsigned ORIGIN_Y   = 0,
    parameter int unsigned BLINK_DIV  = 12500000,
    parameter logic [11:0] BG_RGB     = 12'h0AA,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_col,
    input  logic [RW-1:0] wr_row,
    input  logic [6:0]    wr_char,
    input  logic [3:0]    wr_attr,
    output logic          wr_ready,
    input  logic          clear_req,
    input  logic          cursor_en,
    input  logic [CW-1:0] cursor_col,
    input  logic [RW-1:0] cursor_row,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    rom_data,
    output logic          text_on,
    output logic [11:0]   text_RGB
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0] LAST_CELL  = IW'(CELLS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [CW:0]   COLS_C     = (CW + 1)'(COLS);
    localparam logic [RW:0]   ROWS_C     = (RW + 1)'(ROWS);
    localparam logic [10:0]   ORG_X      = 11'(ORIGIN_X);
    localparam logic [10:0]   ORG_Y      = 11'(ORIGIN_Y);
    localparam logic [11:0]   WIN_W      = 12'(COLS * (8 << SCALE_LOG2));
    localparam logic [11:0]   WIN_H      = 12'(ROWS * (16 << SCALE_LOG2));

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t         state;
    logic [IW-1:0]  sweep;
    logic [BW-1:0]  blink_cnt;
    logic           blink_phase;

    // ---------------------------------------------------------------
    // Control FSM: clear sweep and write acceptance
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            sweep    <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        sweep <= '0;
                    end else if (sweep == LAST_CELL) begin
                        state    <= ST_IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state    <= ST_CLEAR;
                        sweep    <= '0;
                        wr_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Single RAM write port shared by the clear sweep and host writes.
    // A clear request suppresses both (the sweep restarts, the write is lost).
    logic           ram_we;
    logic [IW-1:0]  ram_waddr;
    logic [10:0]    ram_wdata;
    logic           wr_in_range;

    assign wr_in_range = ({1'b0, wr_col} < COLS_C) && ({1'b0, wr_row} < ROWS_C);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep;
        ram_wdata = '0;
        if (!reset && !clear_req) begin
            if (state == ST_CLEAR) begin
                ram_we = 1'b1;
            end else if (wr_en && wr_in_range) begin
                ram_we    = 1'b1;
                ram_waddr = IW'(int'(wr_row) * COLS + int'(wr_col));
                ram_wdata = {wr_char, wr_attr};
            end
        end
    end

    // ---------------------------------------------------------------
    // Blink timebase
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Coordinate decode (combinational, feeds stage 1)
    // ---------------------------------------------------------------
    logic [10:0]   dx, dy;
    logic [10:0]   col_full, row_full;
    logic          in_win;
    logic          cursor_hit;
    logic [IW-1:0] rd_idx;

    assign dx       = {1'b0, pixel_x} - ORG_X;
    assign dy       = {1'b0, pixel_y} - ORG_Y;
    assign col_full = dx >> (SCALE_LOG2 + 3);
    assign row_full = dy >> (SCALE_LOG2 + 4);

    // The >= origin terms reject pixels left of / above the window, whose dx/dy wrap.
    assign in_win = ({1'b0, pixel_x} >= ORG_X) && ({1'b0, dx} < WIN_W) &&
                    ({1'b0, pixel_y} >= ORG_Y) && ({1'b0, dy} < WIN_H);

    assign cursor_hit = cursor_en && blink_phase &&
                        (col_full == 11'(cursor_col)) && (row_full == 11'(cursor_row));

    // Outside the window the cell index is meaningless; park it on cell 0.
    assign rd_idx = in_win ? IW'(int'(row_full) * COLS + int'(col_full)) : '0;

    // ---------------------------------------------------------------
    // Tile RAM: synchronous read, read-first against a same-edge write
    // ---------------------------------------------------------------
    logic [10:0] tile_ram [CELLS];
    logic [10:0] tile_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            tile_ram[ram_waddr] <= ram_wdata;
        end
        tile_q <= tile_ram[rd_idx];
    end

    // ---------------------------------------------------------------
    // Display pipeline
    //   s1: RAM read + side data   s2: rom_addr   s3: wait for rom_data
    //   out: colour select
    // ---------------------------------------------------------------
    logic       s1_valid, s1_win, s1_hit, s1_phase;
    logic [2:0] s1_bit;
    logic [3:0] s1_grow;
    logic       s2_valid, s2_win, s2_hit, s2_phase;
    logic [2:0] s2_bit;
    logic [3:0] s2_attr;
    logic       s3_valid, s3_win, s3_hit, s3_phase;
    logic [2:0] s3_bit;
    logic [3:0] s3_attr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0; s1_win <= 1'b0; s1_hit <= 1'b0; s1_phase <= 1'b0;
            s1_bit   <= '0;   s1_grow <= '0;
            s2_valid <= 1'b0; s2_win <= 1'b0; s2_hit <= 1'b0; s2_phase <= 1'b0;
            s2_bit   <= '0;   s2_attr <= '0;
            s3_valid <= 1'b0; s3_win <= 1'b0; s3_hit <= 1'b0; s3_phase <= 1'b0;
            s3_bit   <= '0;   s3_attr <= '0;
            rom_addr <= '0;
        end else begin
            s1_valid <= 1'b1;
            s1_win   <= in_win;
            s1_hit   <= cursor_hit;
            s1_phase <= blink_phase;
            s1_bit   <= dx[SCALE_LOG2 +: 3];
            s1_grow  <= dy[SCALE_LOG2 +: 4];

            rom_addr <= {tile_q[10:4], s1_grow};
            s2_valid <= s1_valid;
            s2_win   <= s1_win;
            s2_hit   <= s1_hit;
            s2_phase <= s1_phase;
            s2_bit   <= s1_bit;
            s2_attr  <= tile_q[3:0];

            s3_valid <= s2_valid;
            s3_win   <= s2_win;
            s3_hit   <= s2_hit;
            s3_phase <= s2_phase;
            s3_bit   <= s2_bit;
            s3_attr  <= s2_attr;
        end
    end

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'hFFF;
            3'd1:    palette = 12'h2F2;
            3'd2:    palette = 12'hF11;
            3'd3:    palette = 12'h0AA;
            3'd4:    palette = 12'hFF0;
            3'd5:    palette = 12'h00F;
            3'd6:    palette = 12'hF0F;
            default: palette = 12'h888;
        endcase
    endfunction

    logic        glyph_px;
    logic [11:0] fg, on_rgb, off_rgb;

    assign glyph_px = rom_data[3'd7 - s3_bit] & ~(s3_attr[3] & s3_phase);
    assign fg       = palette(s3_attr[2:0]);
    assign on_rgb   = s3_hit ? BG_RGB : fg;
    assign off_rgb  = s3_hit ? fg : BG_RGB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_on  <= 1'b0;
            text_RGB <= 12'h000;
        end else begin
            text_on  <= s3_valid & s3_win;
            text_RGB <= (s3_valid & s3_win) ? (glyph_px ? on_rgb : off_rgb) : 12'h000;
        end
    end

endmodule

// File: tb/tb_text_tile_renderer.sv
// Self-checking bench for text_tile_renderer. A behavioural model holds the
// cell contents, derives each pixel's colour from the coordinate rules and a
// synthetic font, and expects it three clocks later.
module tb_text_tile_renderer;

    localparam int COLS  = 12;
    localparam int ROWS  = 3;
    localparam int S     = 1;
    localparam int OX    = 40;
    localparam int OY    = 20;
    localparam int DIV   = 4;
    localparam int N     = COLS * ROWS;
    localparam int WIN_W = COLS * (8 << S);
    localparam int WIN_H = ROWS * (16 << S);
    localparam logic [11:0] BG = 12'h0AA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_col = '0;
    logic [1:0]  wr_row = '0;
    logic [6:0]  wr_char = '0;
    logic [3:0]  wr_attr = '0;
    logic        wr_ready;
    logic        clear_req = 1'b0;
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_col = '0;
    logic [1:0]  cursor_row = '0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        text_on;
    logic [11:0] text_RGB;

    always #5 clk = ~clk;

    text_tile_renderer #(
        .COLS(COLS), .ROWS(ROWS), .SCALE_LOG2(S), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .BLINK_DIV(DIV), .BG_RGB(BG)
    ) dut (
        .clk(clk), .reset(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
        .wr_attr(wr_attr), .wr_ready(wr_ready), .clear_req(clear_req),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on), .text_RGB(text_RGB)
    );

    // Synthetic font: a scrambled byte per address, mixing lit and dark bits.
    function automatic logic [7:0] font(input logic [10:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd73;
        return t[7:0] ^ {a[10:8], a[4:0]};
    endfunction

    always @(posedge clk) rom_data <= font(rom_addr);

    // ---------------- reference model ----------------
    typedef struct { bit known; bit on; logic [11:0] rgb; } exp_t;

    logic [11:0] pal [8] = '{12'hFFF, 12'h2F2, 12'hF11, 12'h0AA,
                             12'hFF0, 12'h00F, 12'hF0F, 12'h888};
    logic [6:0]  m_char [N];
    logic [3:0]  m_attr [N];
    bit          m_known [N];
    bit          m_clearing;
    int          m_sweep;
    bit          m_ready;
    int          m_edges;
    exp_t        exp_q [$];
    bit          p_rv;
    logic [10:0] p_rom;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z.known = 1'b1; z.on = 1'b0; z.rgb = 12'h000;
        m_clearing = 1'b1; m_sweep = 0; m_ready = 1'b0; m_edges = 0;
        exp_q.delete();
        repeat (3) exp_q.push_back(z);
        p_rv = 1'b0;
    endtask

    // One clock: predict the sampled pixel, advance the model, check outputs.
    task automatic step();
        exp_t e, got;
        int dx, dy, col, row, idx, gr, bt;
        bit ph, lit, hit, rv, nrv;
        logic [10:0] a, rexp;
        logic [7:0] f;
        logic [11:0] fg;
        @(posedge clk);
        if (rst) begin
            model_reset();
            #1;
            check("rst_text_on", text_on, 0);
            check("rst_text_rgb", text_RGB, 0);
            check("rst_wr_ready", wr_ready, 0);
            return;
        end
        dx = int'(pixel_x) - OX;
        dy = int'(pixel_y) - OY;
        e.known = 1'b1; e.rgb = 12'h000; nrv = 1'b0; a = '0;
        e.on = (dx >= 0) && (dy >= 0) && (dx < WIN_W) && (dy < WIN_H);
        if (e.on) begin
            col = dx >> (S + 3);
            row = dy >> (S + 4);
            idx = row * COLS + col;
            gr  = (dy >> S) % 16;
            bt  = (dx >> S) % 8;
            ph  = ((m_edges / DIV) % 2) == 1;
            if (!m_known[idx]) begin
                e.known = 1'b0;
            end else begin
                a   = {m_char[idx], 4'(gr)};
                f   = font(a);
                lit = f[7 - bt] && !(m_attr[idx][3] && ph);
                hit = cursor_en && ph && (col == int'(cursor_col)) && (row == int'(cursor_row));
                fg  = pal[m_attr[idx][2:0]];
                if (hit) e.rgb = lit ? BG : fg;
                else     e.rgb = lit ? fg : BG;
                nrv = 1'b1;
            end
        end
        rv = p_rv; rexp = p_rom;
        p_rv = nrv; p_rom = a;
        exp_q.push_back(e);
        got = exp_q.pop_front();

        if (m_clearing) begin
            if (clear_req) m_sweep = 0;
            else begin
                m_char[m_sweep] = '0; m_attr[m_sweep] = '0; m_known[m_sweep] = 1'b1;
                if (m_sweep == N - 1) begin m_clearing = 1'b0; m_ready = 1'b1; end
                else m_sweep++;
            end
        end else if (clear_req) begin
            m_clearing = 1'b1; m_sweep = 0; m_ready = 1'b0;
        end else if (wr_en && int'(wr_col) < COLS && int'(wr_row) < ROWS) begin
            idx = int'(wr_row) * COLS + int'(wr_col);
            m_char[idx] = wr_char; m_attr[idx] = wr_attr; m_known[idx] = 1'b1;
        end
        m_edges++;

        #1;
        check("wr_ready", wr_ready, m_ready);
        check("text_on", text_on, got.on);
        if (got.known) check("text_rgb", text_RGB, got.rgb);
        if (rv) check("rom_addr", rom_addr, rexp);
    endtask

    task automatic rand_pix();
        if ($urandom_range(0, 7) == 0) begin
            pixel_x = 10'($urandom_range(0, 1023));
            pixel_y = 10'($urandom_range(0, 1023));
        end else begin
            pixel_x = 10'(OX - 4 + int'($urandom_range(0, WIN_W + 8)));
            pixel_y = 10'(OY - 4 + int'($urandom_range(0, WIN_H + 8)));
        end
    endtask

    task automatic put(input int c, input int r, input int ch, input int at);
        wr_en = 1'b1; wr_col = 4'(c); wr_row = 2'(r); wr_char = 7'(ch); wr_attr = 4'(at);
        rand_pix();
        step();
        wr_en = 1'b0;
    endtask

    task automatic hold_pix(input int x, input int y, input int cycles);
        pixel_x = 10'(x); pixel_y = 10'(y);
        repeat (cycles) step();
    endtask

    initial begin
        int low;
        for (int i = 0; i < N; i++) m_known[i] = 1'b0;

        // Reset held, then released mid-cycle.
        repeat (3) step();
        rst = 1'b0;
        low = wr_ready ? 0 : 1;
        for (int i = 0; i < N + 8; i++) begin
            rand_pix(); step();
            if (!wr_ready) low++;
        end
        check("reset_sweep_cycles", low, N);

        // 'A' in palette 2 at column 2, row 1: scan across the cell.
        put(2, 1, 8'h41, 2);
        for (int yi = 0; yi < 4; yi++) begin
            for (int x = 0; x < 16; x++) begin
                pixel_x = 10'(OX + 2 * 16 + x);
                pixel_y = 10'(OY + 32 + yi * 9 % 32);
                step();
            end
        end

        // Random writes, cursor and pixels.
        for (int i = 0; i < 400; i++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_col     = 4'($urandom_range(0, COLS - 1));
            wr_row     = 2'($urandom_range(0, ROWS - 1));
            wr_char    = 7'($urandom);
            wr_attr    = 4'($urandom);
            cursor_en  = 1'($urandom_range(0, 1));
            cursor_col = 4'($urandom_range(0, COLS - 1));
            cursor_row = 2'($urandom_range(0, ROWS - 1));
            rand_pix();
            step();
        end
        wr_en = 1'b0; cursor_en = 1'b0;

        // clear_req together with wr_en: the write to cell 30 must be lost.
        put(6, 2, 8'h5A, 1);
        clear_req = 1'b1; wr_en = 1'b1; wr_col = 4'd6; wr_row = 2'd2;
        wr_char = 7'h41; wr_attr = 4'h2;
        hold_pix(OX + 6 * 16 + 3, OY + 64 + 7, 1);
        clear_req = 1'b0; wr_en = 1'b0;
        low = wr_ready ? 0 : 1;
        for (int i = 0; i < N + 6; i++) begin
            if (i < 20) begin pixel_x = 10'(OX + 6 * 16 + (i % 16)); pixel_y = 10'(OY + 64 + i); end
            else rand_pix();
            step();
            if (!wr_ready) low++;
        end
        check("clear_sweep_cycles", low, N);

        // Clear restarted at sweep index 30.
        for (int i = 0; i < 20; i++)
            put(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)),
                int'($urandom_range(1, 127)), int'($urandom_range(0, 15)));
        clear_req = 1'b1; rand_pix(); step(); clear_req = 1'b0;
        for (int i = 0; i < 30; i++) begin rand_pix(); step(); end
        clear_req = 1'b1; rand_pix(); step(); clear_req = 1'b0;
        low = wr_ready ? 0 : 1;
        for (int i = 0; i < N + 6; i++) begin
            rand_pix(); step();
            if (!wr_ready) low++;
        end
        check("restart_sweep_cycles", low, N);

        // Out-of-range writes are dropped; scan every cell afterwards.
        put(12, 0, 8'h31, 4); put(15, 2, 8'h32, 5); put(0, 3, 8'h33, 6);
        put(13, 3, 8'h34, 7); put(14, 1, 8'h35, 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                hold_pix(OX + c * 16 + 5, OY + r * 32 + 9, 1);

        // Blinking glyph under the blinking cursor, then a steady glyph.
        put(4, 2, 8'h41, 4'hA);
        put(5, 2, 8'h42, 4'h2);
        cursor_en = 1'b1; cursor_col = 4'd4; cursor_row = 2'd2;
        for (int x = 0; x < 16; x += 2) hold_pix(OX + 4 * 16 + x, OY + 64 + 10, 16);
        cursor_col = 4'd5;
        for (int x = 0; x < 16; x += 4) hold_pix(OX + 5 * 16 + x, OY + 64 + 12, 12);
        cursor_en = 1'b0;

        // Window edges.
        hold_pix(OX - 1, OY + 5, 4);
        hold_pix(OX, OY, 4);
        hold_pix(OX + WIN_W - 1, OY + WIN_H - 1, 4);
        hold_pix(OX + WIN_W, OY + 5, 4);
        hold_pix(OX + 5, OY + WIN_H, 4);
        hold_pix(OX + 5, OY - 1, 4);
        hold_pix(1023, 1023, 4);

        // Reset in the middle of a sweep.
        clear_req = 1'b1; rand_pix(); step(); clear_req = 1'b0;
        for (int i = 0; i < 10; i++) begin rand_pix(); step(); end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < N + 10; i++) begin rand_pix(); step(); end
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
